rle_vlc_encoder: RTL and testbench

RLE_VLC_ENCODER -- requirements
Module: rle_vlc_encoder

---
 rtl/mpeg2_vlc_pkg.sv | 25 ++
 rtl/vlc_code_fmt.sv | 39 +++
 rtl/rle_vlc_encoder.sv | 156 +++++++++++++++
 tb/tb_rle_vlc_encoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg2_vlc_pkg.sv
// Shared types and code constants for the MPEG-2 style run/level VLC encoder.
// The optional short code for |level|==1 is enabled by the RLE_SHORT_CODE_EN macro.
package mpeg2_vlc_pkg;

    typedef enum logic [2:0] {
        ACCEPT,
        EMIT_HI,
        EMIT_LO,
        EMIT_SHORT,
        EMIT_EOB,
        GAP,
        DONE
    } vlc_state_e;

    localparam logic [5:0] ESC_CODE  = 6'b000001;
    localparam logic [3:0] ESC_LEN   = 4'd12;
    localparam logic [1:0] EOB_CODE  = 2'b10;
    localparam logic [3:0] EOB_LEN   = 4'd2;
    localparam logic [3:0] SHORT_LEN = 4'd3;

    function automatic logic is_emit_state(input vlc_state_e s);
        return (s == EMIT_HI) || (s == EMIT_LO) || (s == EMIT_SHORT) || (s == EMIT_EOB);
    endfunction

endpackage

// File: rtl/vlc_code_fmt.sv
// Combinational code formatter: maps (state, run, level) to a right-justified code and length.
// The EMIT_SHORT code exists only when RLE_SHORT_CODE_EN is defined.
module vlc_code_fmt
    import mpeg2_vlc_pkg::*;
(
    input  vlc_state_e  state,
    input  logic [5:0]  run,
    input  logic [11:0] level,
    output logic [15:0] code_bits,
    output logic [3:0]  code_len
);

    always_comb begin
        code_bits = '0;
        code_len  = '0;
        case (state)
            EMIT_HI: begin
                code_bits = {4'b0000, ESC_CODE, run};
                code_len  = ESC_LEN;
            end
            EMIT_LO: begin
                code_bits = {4'b0000, level};
                code_len  = ESC_LEN;
            end
`ifdef RLE_SHORT_CODE_EN
            EMIT_SHORT: begin
                code_bits = {13'b0, 2'b11, level[11]};
                code_len  = SHORT_LEN;
            end
`endif
            EMIT_EOB: begin
                code_bits = {14'b0, EOB_CODE};
                code_len  = EOB_LEN;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rle_vlc_encoder.sv
// Run/level VLC encoder: zero runs are counted, nonzero levels emit an escape pair, blocks end in EOB.
// Defining RLE_SHORT_CODE_EN adds a 3-bit code for run 0 with |level|==1.
module rle_vlc_encoder
    import mpeg2_vlc_pkg::*;
#(
    parameter int BLOCK_SIZE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] coef,
    input  logic        coef_valid,
    input  logic        coef_last,
    output logic        coef_ready,
    input  logic        out_rdy,
    output logic        out_en,
    output logic [15:0] out_bits,
    output logic [3:0]  out_len,
    output logic        block_done
);

    localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

    vlc_state_e       state_q, state_d;
    vlc_state_e       after_gap_q, after_gap_d;
    logic [5:0]       run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      level_q, level_d;
    logic             end_pend_q, end_pend_d;
    logic [15:0]      out_bits_q, out_bits_d;
    logic [3:0]       out_len_q, out_len_d;
    logic             block_done_q, block_done_d;

    logic [15:0]      fmt_bits;
    logic [3:0]       fmt_len;
    logic             blk_end;
    logic [11:0]      level_clamped;

    assign coef_ready    = (state_q == ACCEPT);
    // Delivery is qualified by the live out_rdy; reset suppresses it in the reset cycle too.
    assign out_en        = is_emit_state(state_q) && out_rdy && !reset;
    assign out_bits      = out_bits_q;
    assign out_len       = out_len_q;
    assign block_done    = block_done_q;

    assign blk_end       = coef_last || ((cnt_q + CNT_W'(1)) == CNT_W'(BLOCK_SIZE));
    assign level_clamped = (coef == 12'h800) ? 12'h801 : coef;

`ifdef RLE_SHORT_CODE_EN
    logic short_ok;
    assign short_ok = (run_q == 6'd0) && ((coef == 12'h001) || (coef == 12'hFFF));
`endif

    always_comb begin
        state_d      = state_q;
        after_gap_d  = after_gap_q;
        run_d        = run_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        end_pend_d   = end_pend_q;
        block_done_d = 1'b0;
        case (state_q)
            ACCEPT: begin
                if (coef_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (coef == 12'h000) begin
                        run_d = run_q + 6'd1;
                        if (blk_end) begin
                            state_d = EMIT_EOB;
                        end
                    end else begin
                        level_d    = level_clamped;
                        end_pend_d = blk_end;
                        state_d    = EMIT_HI;
`ifdef RLE_SHORT_CODE_EN
                        if (short_ok) begin
                            state_d = EMIT_SHORT;
                        end
`endif
                    end
                end
            end
            EMIT_HI: begin
                if (out_rdy) begin
                    state_d     = GAP;
                    after_gap_d = EMIT_LO;
                end
            end
`ifdef RLE_SHORT_CODE_EN
            EMIT_LO, EMIT_SHORT: begin
`else
            EMIT_LO: begin
`endif
                if (out_rdy) begin
                    state_d     = GAP;
                    run_d       = '0;
                    after_gap_d = end_pend_q ? EMIT_EOB : ACCEPT;
                end
            end
            EMIT_EOB: begin
                // Any trailing zero run is dropped here along with the block position.
                if (out_rdy) begin
                    state_d      = DONE;
                    run_d        = '0;
                    cnt_d        = '0;
                    block_done_d = 1'b1;
                end
            end
            GAP:     state_d = after_gap_q;
            DONE:    state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    vlc_code_fmt u_fmt (
        .state     (state_d),
        .run       (run_d),
        .level     (level_d),
        .code_bits (fmt_bits),
        .code_len  (fmt_len)
    );

    // Code is captured on entry to an emission state and held until it is delivered.
    always_comb begin
        out_bits_d = out_bits_q;
        out_len_d  = out_len_q;
        if (is_emit_state(state_d) && (state_d != state_q)) begin
            out_bits_d = fmt_bits;
            out_len_d  = fmt_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCEPT;
            after_gap_q  <= ACCEPT;
            run_q        <= '0;
            cnt_q        <= '0;
            level_q      <= '0;
            end_pend_q   <= 1'b0;
            out_bits_q   <= '0;
            out_len_q    <= '0;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            after_gap_q  <= after_gap_d;
            run_q        <= run_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            end_pend_q   <= end_pend_d;
            out_bits_q   <= out_bits_d;
            out_len_q    <= out_len_d;
            block_done_q <= block_done_d;
        end
    end

endmodule

// File: tb/tb_rle_vlc_encoder.sv
// Directed and randomised bench for rle_vlc_encoder with a code scoreboard.
// Expected codes follow RLE_SHORT_CODE_EN when it is defined for the build.
module tb_rle_vlc_encoder;

    logic        clk;
    logic        reset;
    logic [11:0] coef;
    logic        coef_valid;
    logic        coef_last;
    logic        coef_ready;
    logic        out_rdy;
    logic        out_en;
    logic [15:0] out_bits;
    logic [3:0]  out_len;
    logic        block_done;

    int          checks   = 0;
    int          failures = 0;
    logic [19:0] sb[$];
    logic [5:0]  m_run  = '0;
    int          m_cnt  = 0;
    int          m_done = 0;
    int          done_cnt = 0;
    logic        rdy_rand = 1'b0;

    rle_vlc_encoder #(.BLOCK_SIZE(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .coef       (coef),
        .coef_valid (coef_valid),
        .coef_last  (coef_last),
        .coef_ready (coef_ready),
        .out_rdy    (out_rdy),
        .out_en     (out_en),
        .out_bits   (out_bits),
        .out_len    (out_len),
        .block_done (block_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: push the codes a coefficient should produce.
    task automatic model_coef(input logic [11:0] c, input logic l);
        logic [11:0] lv;
        logic        used_short;
        m_cnt++;
        if (c == 12'h000) begin
            m_run = m_run + 6'd1;
        end else begin
            lv = (c == 12'h800) ? 12'h801 : c;
            used_short = 1'b0;
`ifdef RLE_SHORT_CODE_EN
            if (m_run == 6'd0 && (c == 12'h001 || c == 12'hFFF)) begin
                sb.push_back({4'd3, 13'b0, 2'b11, c[11]});
                used_short = 1'b1;
            end
`endif
            if (!used_short) begin
                sb.push_back({4'd12, 4'h0, 6'b000001, m_run});
                sb.push_back({4'd12, 4'h0, lv});
            end
            m_run = '0;
        end
        if (l || m_cnt == 64) begin
            sb.push_back({4'd2, 16'h0002});
            m_run = '0;
            m_cnt = 0;
            m_done++;
        end
    endtask

    task automatic send_coef(input logic [11:0] c, input logic l);
        int n;
        model_coef(c, l);
        coef = c;
        coef_last = l;
        coef_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (coef_ready) break;
            n++;
            if (n > 2000) begin
                chk("accept_timeout", 32'(coef_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        coef_valid = 1'b0;
        coef_last = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0 && coef_ready) break;
            n++;
            if (n > 3000) begin
                chk({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
                sb.delete();
                break;
            end
        end
        chk({tag, "_block_done_count"}, 32'(done_cnt), 32'(m_done));
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every delivered code.
    initial begin
        logic        prev_en;
        logic        prev_eob;
        logic [19:0] exp;
        prev_en  = 1'b0;
        prev_eob = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en  = 1'b0;
                prev_eob = 1'b0;
            end else begin
                if (block_done) begin
                    chk("block_done_after_eob", 32'(prev_eob), 32'd1);
                    done_cnt++;
                end
                if (out_en) begin
                    chk("gap_spacing", 32'(prev_en), 32'd0);
                    exp = (sb.size() > 0) ? sb.pop_front() : 20'hxxxxx;
                    chk("code", {12'h0, out_len, out_bits}, {12'h0, exp});
                    $display("code bits=%04h len=%0d", out_bits, out_len);
                end
                prev_eob = out_en && (out_len == 4'd2) && (out_bits == 16'h0002);
                prev_en  = out_en;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [11:0] c;
        int          r;
        reset = 1'b1;
        coef = '0;
        coef_valid = 1'b0;
        coef_last = 1'b0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_en", 32'(out_en), 32'd0);
        chk("reset_out_bits", 32'(out_bits), 32'd0);
        chk("reset_out_len", 32'(out_len), 32'd0);
        chk("reset_block_done", 32'(block_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(coef_ready), 32'd1);
        @(posedge clk);
        #1;

        // Leading zeros become the run of the escape pair.
        send_coef(12'h000, 1'b0);
        send_coef(12'h000, 1'b0);
        send_coef(12'h005, 1'b1);
        drain("run2_level5");

        // Trailing zeros produce no code; the next block starts at run 0.
        send_coef(12'hFFD, 1'b0);
        send_coef(12'h000, 1'b0);
        send_coef(12'h000, 1'b1);
        drain("neg3_trailing");
        send_coef(12'h004, 1'b1);
        drain("run_cleared");

        // A full block of zeros without coef_last yields only EOB.
        for (int i = 0; i < 64; i++) send_coef(12'h000, 1'b0);
        drain("zeros64");
        send_coef(12'h007, 1'b1);
        drain("after_zeros64");

        // Nonzero at the 64th position: run 63 then EOB.
        for (int i = 0; i < 63; i++) send_coef(12'h000, 1'b0);
        send_coef(12'h003, 1'b0);
        drain("run63_pos64");

        send_coef(12'h800, 1'b1);
        drain("clamp_m2048");

        // Backpressure frozen in EMIT_HI.
        out_rdy = 1'b0;
        send_coef(12'h009, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_en", 32'(out_en), 32'd0);
            chk("bp_coef_ready", 32'(coef_ready), 32'd0);
            chk("bp_out_bits", {12'h0, out_len, out_bits}, {12'h0, 4'd12, 16'h0040});
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        drain("backpressure");

        send_coef(12'hFFF, 1'b1);
        drain("minus1_run0");
        send_coef(12'h000, 1'b0);
        send_coef(12'h001, 1'b1);
        drain("plus1_run1");

        // Randomised coefficients with random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)       c = 12'h000;
            else if (r == 5) c = 12'h001;
            else if (r == 6) c = 12'hFFF;
            else if (r == 7) c = 12'h800;
            else             c = 12'($urandom_range(1, 4095));
            send_coef(c, (i == 19) || (i == 39));
        end
        drain("random");
        rdy_rand = 1'b0;
        #2;
        out_rdy = 1'b1;

        // Reset while parked in EMIT_LO abandons the low code.
        out_rdy = 1'b0;
        coef = 12'h006;
        coef_last = 1'b1;
        coef_valid = 1'b1;
        @(posedge clk);
        #1;
        coef_valid = 1'b0;
        coef_last = 1'b0;
        sb.push_back({4'd12, 16'h0040});
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("lo_parked_bits", {12'h0, out_len, out_bits}, {12'h0, 4'd12, 16'h0006});
        reset = 1'b1;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_run = '0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_out_en", 32'(out_en), 32'd0);
            chk("post_reset_ready", 32'(coef_ready), 32'd1);
        end
        chk("abandoned_code_sb", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        send_coef(12'h002, 1'b1);
        drain("after_mid_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
